// File: rtl/button_pulse_shaper_if.sv
// Signal bundle between the raw pushbutton side and the debounced outputs.
// The shaper takes the slave modport; the stimulus side (pin driver / consumer) takes master.
interface button_pulse_shaper_if #(
  parameter int CNT_W = 8
);
  logic             btn_n_in;
  logic             btn_pulse;
  logic             btn_level;
  logic [CNT_W-1:0] press_count;

  modport master (
    output btn_n_in,
    input  btn_pulse,
    input  btn_level,
    input  press_count
  );

  modport slave (
    input  btn_n_in,
    output btn_pulse,
    output btn_level,
    output press_count
  );
endinterface

// File: rtl/button_pulse_shaper.sv
// Synchronises and debounces an active-low pushbutton; one pulse per accepted press.
// Define BUTTON_AUTOREPEAT_EN to build the auto-repeat counter (pulse every REPEAT_CYCLES while held).
module button_pulse_shaper #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 16,
  parameter int CNT_W           = 8
) (
  input logic                  clk,
  input logic                  rst,
  button_pulse_shaper_if.slave bus
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q;
  logic [DB_W-1:0]  cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept, release_done, rep_fire;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int RP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);
  logic [RP_W-1:0] rep_q, rep_d;
  logic            rep_hit;
  assign rep_hit  = (rep_q == RP_LAST);
  assign rep_fire = (state_q == HELD) && !s2_q && rep_hit;
`else
  assign rep_fire = 1'b0;
`endif

  // State register, synchroniser and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
      count_q <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      s1_q    <= bus.btn_n_in;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
      count_q <= count_d;
`ifdef BUTTON_AUTOREPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef BUTTON_AUTOREPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (!s2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (s2_q) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
`ifdef BUTTON_AUTOREPEAT_EN
          rep_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (s2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
`ifdef BUTTON_AUTOREPEAT_EN
        else if (rep_hit) rep_d = '0;
        else              rep_d = rep_q + 1'b1;
`endif
      end
      RELEASE_WAIT: begin
        // Low again before the release is accepted: a bounce, not a new press
        if (!s2_q) begin
          state_d = HELD;
`ifdef BUTTON_AUTOREPEAT_EN
          rep_d   = '0;
`endif
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic (feeds the output registers)
  always_comb begin
    accept       = (state_q == PRESS_WAIT) && !s2_q && (cnt_q == DB_LAST);
    release_done = (state_q == RELEASE_WAIT) && s2_q && (cnt_q == DB_LAST);
    pulse_d      = accept | rep_fire;
    level_d      = level_q;
    if (accept)       level_d = 1'b1;
    if (release_done) level_d = 1'b0;
    count_d      = count_q + CNT_W'(pulse_d);
  end

  assign bus.btn_pulse   = pulse_q;
  assign bus.btn_level   = level_q;
  assign bus.press_count = count_q;

endmodule
